scalar_dmem_responder: RTL and testbench
========================================

Name: scalar_dmem_responder

Overview:
Memory-side responder for the scalar load/store unit's dmem request interface.
- Accepts one load or store at a time from `dmemaddr`/`dmemREN`/`dmemWEN`/`dmemstore`.
- Models a fixed-latency data memory over an internal word array.
- Pulses `dhit` with `dmemload` when the access completes.
- Sits between the scalar LS functional unit and the data memory; used as the real scratch data memory and as the bench responder for LS verification.

Parameters:
- DEPTH_WORDS, 256: number of 32-bit words in the array; power of two.
- LATENCY, 2: cycles from request acceptance to `dhit`; must be >= 1.

Ports:
- CLK  input  1  clock; all logic on the rising edge.
- RST  input  1  reset, synchronous, active-high.
- dmemaddr  input  32  byte address of the request (word_t).
- dmemREN  input  1  load request; held by the requester until `dhit`.
- dmemWEN  input  1  store request; held by the requester until `dhit`.
- dmemstore  input  32  store data (word_t).
- dhit  output  1  one-cycle completion pulse.
- dmemload  output  32  load data; valid only while `dhit`=1 for a read.
- busy  output  1  a request is latched and in flight.
- misaligned  output  1  one-cycle pulse with `dhit` when the completed request had `addr[1:0]`!=0.

Behaviour:
- Reset (RST=1 at a clock edge):
  - state<=IDLE, counter<=0, latched request cleared.
  - `dhit`, `dmemload`, `busy`, `misaligned` all read 0 in the following cycle.
  - Array contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If `dmemREN|dmemWEN` at an edge, latch addr, store data, and op. WEN has priority when both are set; the op is latched as a write.
  - Load counter with LATENCY-1.
  - Go to RESP if LATENCY==1, else to WAIT.
- WAIT:
  - Decrement counter; go to RESP when counter reaches 1.
  - Input changes are ignored (the request is latched).
  - If REN/WEN drop, the transaction still completes.
- RESP (exactly one cycle), registered outputs:
  - `dhit`=1.
  - For a read, `dmemload`=array[index]; for a write, `dmemload`=0.
  - For a write, the array is updated at the edge ending RESP.
  - `misaligned` reflects the latched `addr[1:0]`.
  - Next state is always IDLE. Requests present during RESP are ignored: the requester drops REN/WEN combinationally on `dhit`.
- Latency:
  - Request first seen in IDLE at edge t; `dhit` is high in the cycle after edge t+LATENCY-1, i.e. LATENCY cycles after acceptance.
  - Back-to-back requests are re-accepted in the IDLE cycle after RESP.
  - Minimum spacing between hits is LATENCY+1 cycles.
- `busy`=1 in WAIT and RESP, 0 in IDLE.
- Address mapping:
  - index = `addr[2 +: log2(DEPTH_WORDS)]`; upper bits are ignored (aliasing wrap-around).
  - Low two bits are ignored for data but flagged via `misaligned`.
- Read-after-write to the same index on the next request returns the new data, since the write commits before the next acceptance.
- Reset mid-operation: RST in WAIT or RESP aborts the transaction; no `dhit`, and no write commit (write-enable is gated by !RST).
- `dhit` never asserts in two consecutive cycles.

Decomposition:
- datapath_pkg: reuse `word_t`.
- Add `dmem_resp_state_t` (IDLE/WAIT/RESP) and `DMEM_WORD_OFFSET`=2 to datapath_pkg.
- Sub-module `dmem_array`:
  - DEPTH_WORDS x 32.
  - Synchronous write, combinational read.
  - Ports: CLK, wen, windex, wdata, rindex, rdata.
- FSM and counter stay in the top module.

Test Plan:
1. Reset then store: WEN=1, addr=0x0000_0010, data=0xDEAD_BEEF, held until hit (LATENCY=2) -> `dhit` exactly 2 cycles after acceptance, `busy` high 2 cycles, `misaligned`=0.
2. Load-back: REN=1, addr=0x10 -> `dhit` after 2 cycles with `dmemload`=0xDEAD_BEEF. A load of addr 0x10+4*DEPTH_WORDS (0x410) also returns 0xDEAD_BEEF (alias).
3. Back-to-back with LATENCY=1: store 0x1 to 0x20, then immediately load 0x20 -> hits 2 cycles apart, load returns 0x0000_0001, no consecutive `dhit`.
4. Simultaneous REN+WEN at addr 0x30, data 0x55 -> treated as a write (`dmemload`=0); a subsequent load of 0x30 returns 0x55.
5. Misaligned: load addr 0x13 after 0x10 holds 0xDEAD_BEEF -> `dhit` with `dmemload`=0xDEAD_BEEF and `misaligned`=1 in the same cycle.
6. RST asserted in WAIT of a store of 0xAAAA to 0x40 (0x40 previously held 0x1234) -> no `dhit`, `busy`=0 next cycle, a later load of 0x40 returns 0x1234.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared datapath types for the scalar load/store path.
// Holds the word type and the dmem responder state encoding.
package datapath_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_resp_state_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } dmem_op_t;

    localparam int DMEM_WORD_OFFSET = 2;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed data memory array.
// Synchronous write port, combinational read port.
module dmem_array
    import datapath_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    localparam int IW = $clog2(DEPTH_WORDS)
) (
    input  logic          CLK,
    input  logic          wen,
    input  logic [IW-1:0] windex,
    input  word_t         wdata,
    input  logic [IW-1:0] rindex,
    output word_t         rdata
);

    word_t mem [DEPTH_WORDS];

    // Commit a write on the rising edge; contents are never reset.
    always_ff @(posedge CLK) begin
        if (wen) begin
            mem[windex] <= wdata;
        end
    end

    assign rdata = mem[rindex];

endmodule

// File: rtl/scalar_dmem_responder.sv
// Fixed-latency data memory responder for the scalar LS unit.
// One request in flight; completion signalled by a one-cycle dhit.
module scalar_dmem_responder
    import datapath_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic  CLK,
    input  logic  RST,
    input  word_t dmemaddr,
    input  logic  dmemREN,
    input  logic  dmemWEN,
    input  word_t dmemstore,
    output logic  dhit,
    output word_t dmemload,
    output logic  busy,
    output logic  misaligned
);

    localparam int IW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    dmem_resp_state_t state;
    logic [CW-1:0]    count;
    logic [IW-1:0]    req_index;
    logic [1:0]       req_low;
    word_t            req_data;
    dmem_op_t         req_op;

    logic          req;
    dmem_op_t      in_op;
    logic [IW-1:0] in_index;
    logic [IW-1:0] rindex;
    word_t         rdata;
    logic          wen;
    dmem_op_t      cur_op;
    logic [1:0]    cur_low;
    word_t         resp_load;
    logic          resp_mis;

    // Upper address bits alias onto the array and are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^dmemaddr[31:DMEM_WORD_OFFSET+IW];

    assign req      = dmemREN | dmemWEN;
    assign in_op    = dmemWEN ? OP_WRITE : OP_READ;
    assign in_index = dmemaddr[DMEM_WORD_OFFSET +: IW];

    // A write only commits at the edge that ends RESP, and never under reset.
    assign wen = (state == RESP) && (req_op == OP_WRITE) && !RST;

    // In IDLE the response may be built straight from the inputs (LATENCY 1).
    always_comb begin
        rindex    = req_index;
        cur_op    = req_op;
        cur_low   = req_low;
        if (state == IDLE) begin
            rindex  = in_index;
            cur_op  = in_op;
            cur_low = dmemaddr[1:0];
        end
        resp_load = (cur_op == OP_READ) ? rdata : '0;
        resp_mis  = |cur_low;
    end

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .CLK   (CLK),
        .wen   (wen),
        .windex(req_index),
        .wdata (req_data),
        .rindex(rindex),
        .rdata (rdata)
    );

    // Request FSM, latency counter and registered response outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            count      <= '0;
            req_index  <= '0;
            req_low    <= '0;
            req_data   <= '0;
            req_op     <= OP_READ;
            dhit       <= 1'b0;
            dmemload   <= '0;
            busy       <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            dhit       <= 1'b0;
            dmemload   <= '0;
            misaligned <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req) begin
                        req_index <= in_index;
                        req_low   <= dmemaddr[1:0];
                        req_data  <= dmemstore;
                        req_op    <= in_op;
                        count     <= CW'(LATENCY - 1);
                        busy      <= 1'b1;
                        if (LATENCY == 1) begin
                            state      <= RESP;
                            dhit       <= 1'b1;
                            dmemload   <= resp_load;
                            misaligned <= resp_mis;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (count == CW'(1)) begin
                        state      <= RESP;
                        dhit       <= 1'b1;
                        dmemload   <= resp_load;
                        misaligned <= resp_mis;
                    end
                    count <= count - CW'(1);
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scalar_dmem_responder.sv
// Directed bench for scalar_dmem_responder.
// Uses a LATENCY=2 instance and a LATENCY=1 instance.
module tb_scalar_dmem_responder;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] dmemaddr = '0;
    logic        dmemREN = 1'b0;
    logic        dmemWEN = 1'b0;
    logic [31:0] dmemstore = '0;
    logic        dhit;
    logic [31:0] dmemload;
    logic        busy;
    logic        misaligned;

    logic [31:0] f_addr = '0;
    logic        f_ren = 1'b0;
    logic        f_wen = 1'b0;
    logic [31:0] f_store = '0;
    logic        f_dhit;
    logic [31:0] f_load;
    logic        f_busy;
    logic        f_mis;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    scalar_dmem_responder #(
        .DEPTH_WORDS(256),
        .LATENCY    (2)
    ) u_dut (
        .CLK       (CLK),
        .RST       (RST),
        .dmemaddr  (dmemaddr),
        .dmemREN   (dmemREN),
        .dmemWEN   (dmemWEN),
        .dmemstore (dmemstore),
        .dhit      (dhit),
        .dmemload  (dmemload),
        .busy      (busy),
        .misaligned(misaligned)
    );

    scalar_dmem_responder #(
        .DEPTH_WORDS(256),
        .LATENCY    (1)
    ) u_fast (
        .CLK       (CLK),
        .RST       (RST),
        .dmemaddr  (f_addr),
        .dmemREN   (f_ren),
        .dmemWEN   (f_wen),
        .dmemstore (f_store),
        .dhit      (f_dhit),
        .dmemload  (f_load),
        .busy      (f_busy),
        .misaligned(f_mis)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request, hold it until dhit, then check the response.
    task automatic xfer(input string tag, input logic w, input logic r,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_load, input logic exp_mis);
        int          lat;
        int          bcnt;
        logic [31:0] load;
        logic        mis;
        lat  = 0;
        bcnt = 0;
        load = '0;
        mis  = 1'b0;
        @(negedge CLK);
        dmemWEN   = w;
        dmemREN   = r;
        dmemaddr  = a;
        dmemstore = d;
        for (int i = 1; i <= 10; i++) begin
            @(negedge CLK);
            if (busy) bcnt++;
            if (dhit) begin
                lat  = i;
                load = dmemload;
                mis  = misaligned;
                break;
            end
        end
        dmemWEN = 1'b0;
        dmemREN = 1'b0;
        check({tag, "_lat"}, lat, 2);
        check({tag, "_busy"}, bcnt, 2);
        check({tag, "_load"}, load, exp_load);
        check({tag, "_mis"}, {31'b0, mis}, {31'b0, exp_mis});
        @(negedge CLK);
        check({tag, "_gap"}, {31'b0, dhit}, 0);
        check({tag, "_idle"}, {31'b0, busy}, 0);
    endtask

    initial begin
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_dhit", {31'b0, dhit}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_mis", {31'b0, misaligned}, 0);
        check("rst_load", dmemload, 0);
        check("rst_fdhit", {31'b0, f_dhit}, 0);
        RST = 1'b0;

        xfer("st10", 1, 0, 32'h10, 32'hDEAD_BEEF, 32'h0, 0);
        xfer("ld10", 0, 1, 32'h10, 32'h0, 32'hDEAD_BEEF, 0);
        xfer("ld410", 0, 1, 32'h410, 32'h0, 32'hDEAD_BEEF, 0);

        @(negedge CLK);
        f_wen   = 1'b1;
        f_addr  = 32'h20;
        f_store = 32'h1;
        @(negedge CLK);
        check("f_st_hit", {31'b0, f_dhit}, 1);
        check("f_st_load", f_load, 0);
        f_wen  = 1'b0;
        f_ren  = 1'b1;
        @(negedge CLK);
        check("f_nocons", {31'b0, f_dhit}, 0);
        @(negedge CLK);
        check("f_ld_hit", {31'b0, f_dhit}, 1);
        check("f_ld_load", f_load, 32'h1);
        f_ren = 1'b0;
        @(negedge CLK);
        check("f_ld_gap", {31'b0, f_dhit}, 0);

        xfer("rw30", 1, 1, 32'h30, 32'h55, 32'h0, 0);
        xfer("ld30", 0, 1, 32'h30, 32'h0, 32'h55, 0);
        xfer("ld13", 0, 1, 32'h13, 32'h0, 32'hDEAD_BEEF, 1);

        xfer("st40", 1, 0, 32'h40, 32'h1234, 32'h0, 0);
        @(negedge CLK);
        dmemWEN   = 1'b1;
        dmemaddr  = 32'h40;
        dmemstore = 32'hAAAA;
        @(negedge CLK);
        check("rw_busy", {31'b0, busy}, 1);
        check("rw_dhit", {31'b0, dhit}, 0);
        RST     = 1'b1;
        dmemWEN = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        check("rw_busy0", {31'b0, busy}, 0);
        check("rw_dhit0", {31'b0, dhit}, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("rw_nohit", {31'b0, dhit}, 0);
        end
        xfer("ld40a", 0, 1, 32'h40, 32'h0, 32'h1234, 0);

        @(negedge CLK);
        dmemWEN   = 1'b1;
        dmemaddr  = 32'h40;
        dmemstore = 32'hBBBB;
        @(negedge CLK);
        @(negedge CLK);
        check("rr_dhit", {31'b0, dhit}, 1);
        RST     = 1'b1;
        dmemWEN = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        check("rr_dhit0", {31'b0, dhit}, 0);
        check("rr_busy0", {31'b0, busy}, 0);
        xfer("ld40b", 0, 1, 32'h40, 32'h0, 32'h1234, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
